// File: rtl/matvec_row_sched_if.sv
// Handshake bundle between the matrix-vector row scheduler and its
// controller, loader, accumulator and drain partners.
interface matvec_row_sched_if;
    logic       set;
    logic       start;
    logic [2:0] k_param;
    logic       abort;
    logic       ld_req;
    logic [2:0] ld_row;
    logic       ld_ack;
    logic       acc_full_in;
    logic       acc_cal_en;
    logic       acc_done;
    logic       out_req;
    logic       out_ack;
    logic       busy;
    logic       done;
    logic [1:0] err;

    modport master (
        input  set, start, k_param, abort, ld_ack, acc_done, out_ack,
        output ld_req, ld_row, acc_full_in, acc_cal_en, out_req, busy, done, err
    );

    modport slave (
        output set, start, k_param, abort, ld_ack, acc_done, out_ack,
        input  ld_req, ld_row, acc_full_in, acc_cal_en, out_req, busy, done, err
    );
endinterface

// File: rtl/matvec_row_sched.sv
// Sequences K rows of a matrix-vector product: load, accumulate, drain per row,
// with a per-wait-state watchdog, abort, and a global hold enable.
module matvec_row_sched #(
    parameter logic [15:0] TIMEOUT = 16'hFFFF
) (
    input  logic               clk,
    input  logic               reset_n,
    matvec_row_sched_if.master bus
);
    typedef enum logic [3:0] {
        IDLE, LD_REQ, LD_WAIT, FULL, CAL, ACC_LOW, ACC_HIGH,
        OUT_REQ, OUT_WAIT, NEXT, FIN
    } state_t;

    localparam logic [15:0] WD_LAST = TIMEOUT - 16'd1;

    state_t      state_q, state_d;
    logic [2:0]  row_q, row_d;
    logic [2:0]  k_q, k_d;
    logic [15:0] wd_q, wd_d;
    logic [1:0]  err_q, err_d;
    logic [2:0]  ld_row_q, ld_row_d;
    logic        ld_req_q, ld_req_d;
    logic        full_q, full_d;
    logic        cal_q, cal_d;
    logic        out_req_q, out_req_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic k_legal;
    logic waiting;
    logic wd_expired;

    assign k_legal    = bus.k_param inside {3'd2, 3'd3, 3'd4};
    assign waiting    = state_q inside {LD_WAIT, ACC_LOW, ACC_HIGH, OUT_WAIT};
    assign wd_expired = waiting && (wd_q >= WD_LAST);

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        k_d       = k_q;
        wd_d      = wd_q;
        err_d     = err_q;
        ld_row_d  = ld_row_q;
        ld_req_d  = ld_req_q;
        full_d    = full_q;
        cal_d     = cal_q;
        out_req_d = out_req_q;
        busy_d    = busy_q;
        done_d    = done_q;

        if (bus.set) begin
            if (bus.abort) begin
                state_d = IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (bus.start) begin
                            if (k_legal) begin
                                k_d     = bus.k_param;
                                row_d   = 3'd0;
                                err_d   = 2'd0;
                                state_d = LD_REQ;
                            end else begin
                                err_d = 2'd1;
                            end
                        end
                    end
                    LD_REQ:   state_d = LD_WAIT;
                    LD_WAIT:  if (bus.ld_ack) state_d = FULL;
                    FULL:     state_d = CAL;
                    CAL:      state_d = ACC_LOW;
                    // A level still high from the previous row is not a completion.
                    ACC_LOW:  if (!bus.acc_done) state_d = ACC_HIGH;
                    ACC_HIGH: if (bus.acc_done) state_d = OUT_REQ;
                    OUT_REQ:  state_d = OUT_WAIT;
                    OUT_WAIT: if (bus.out_ack) state_d = NEXT;
                    NEXT: begin
                        if (row_q == k_q - 3'd1) begin
                            state_d = FIN;
                        end else begin
                            row_d   = row_q + 3'd1;
                            state_d = LD_REQ;
                        end
                    end
                    FIN:      state_d = IDLE;
                    default:  state_d = IDLE;
                endcase

                // Watchdog only fires when the wait state would otherwise persist.
                if (wd_expired && (state_d == state_q)) begin
                    state_d = IDLE;
                    err_d   = 2'd2;
                end
            end

            if (state_d != state_q) begin
                wd_d = 16'd0;
            end else if (waiting) begin
                wd_d = wd_q + 16'd1;
            end

            // Outputs are registered copies of the decoded next state.
            ld_req_d  = (state_d == LD_REQ);
            full_d    = (state_d == FULL);
            cal_d     = (state_d == CAL);
            out_req_d = (state_d == OUT_REQ);
            done_d    = (state_d == FIN);
            busy_d    = (state_d != IDLE);
            ld_row_d  = (state_d == IDLE) ? 3'd0 : row_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            row_q     <= 3'd0;
            k_q       <= 3'd0;
            wd_q      <= 16'd0;
            err_q     <= 2'd0;
            ld_row_q  <= 3'd0;
            ld_req_q  <= 1'b0;
            full_q    <= 1'b0;
            cal_q     <= 1'b0;
            out_req_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            k_q       <= k_d;
            wd_q      <= wd_d;
            err_q     <= err_d;
            ld_row_q  <= ld_row_d;
            ld_req_q  <= ld_req_d;
            full_q    <= full_d;
            cal_q     <= cal_d;
            out_req_q <= out_req_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.ld_req      = ld_req_q;
    assign bus.ld_row      = ld_row_q;
    assign bus.acc_full_in = full_q;
    assign bus.acc_cal_en  = cal_q;
    assign bus.out_req     = out_req_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.err         = err_q;
endmodule

// File: tb/tb_matvec_row_sched.sv
// Bench for matvec_row_sched: the bench plays controller, loader, accumulator
// and drain, predicting each handshake from the row-by-row protocol rules.
module tb_matvec_row_sched;
    logic clk;
    logic reset_n;
    matvec_row_sched_if bus();

    matvec_row_sched #(.TIMEOUT(16'd20)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int c_ldreq = 0, c_full = 0, c_cal = 0, c_outreq = 0, c_done = 0;
    logic p_ldreq = 0, p_full = 0, p_cal = 0, p_outreq = 0, p_done = 0;

    typedef struct {
        logic [2:0] k;
        logic [1:0] err_exp;
        logic       busy_exp;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [10:0] outs();
        return {bus.ld_req, bus.ld_row, bus.acc_full_in, bus.acc_cal_en,
                bus.out_req, bus.busy, bus.done, bus.err};
    endfunction

    // Pulse counting and single-cycle width checks, sampled just after each edge.
    always @(posedge clk) begin
        #1;
        if (reset_n) begin
            if (bus.ld_req)      c_ldreq++;
            if (bus.acc_full_in) c_full++;
            if (bus.acc_cal_en)  c_cal++;
            if (bus.out_req)     c_outreq++;
            if (bus.done)        c_done++;
            if (bus.set) begin
                if (p_ldreq)  chk("ld_req_width", bus.ld_req, 0);
                if (p_full)   chk("full_width", bus.acc_full_in, 0);
                if (p_cal)    chk("cal_width", bus.acc_cal_en, 0);
                if (p_outreq) chk("out_req_width", bus.out_req, 0);
                if (p_done)   chk("done_width", bus.done, 0);
            end
            p_ldreq = bus.ld_req; p_full = bus.acc_full_in; p_cal = bus.acc_cal_en;
            p_outreq = bus.out_req; p_done = bus.done;
        end else begin
            p_ldreq = 0; p_full = 0; p_cal = 0; p_outreq = 0; p_done = 0;
        end
    end

    // One row, entered at the negedge where ld_req should be visible.
    task automatic do_row(input int r, input int ad, input int s, input int c,
                          input bit stale, input int od, input bit spur);
        bit a[64];
        int i0, i1, lat;
        chk("ld_req_rise", bus.ld_req, 1);
        chk("ld_row_load", bus.ld_row, r);
        bus.ld_ack = spur;
        for (int i = 1; i <= ad; i++) begin
            tick();
            bus.ld_ack = (i == ad);
        end
        tick();
        bus.ld_ack = 1'b0;
        chk("acc_full_in", bus.acc_full_in, 1);
        chk("ld_row_full", bus.ld_row, r);
        tick();
        chk("acc_cal_en", bus.acc_cal_en, 1);
        chk("full_drop", bus.acc_full_in, 0);
        for (int i = 0; i < 64; i++) a[i] = (i <= s) ? stale : ((i <= s + c) ? 1'b0 : 1'b1);
        i0 = 1;
        while (a[i0] != 1'b0) i0++;
        i1 = i0 + 1;
        while (a[i1] != 1'b1) i1++;
        bus.acc_done = a[0];
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (bus.out_req) begin
                lat = i;
                break;
            end
            bus.acc_done = a[i];
        end
        chk("out_req_latency", lat, i1 + 1);
        chk("ld_row_drain", bus.ld_row, r);
        for (int i = 1; i <= od; i++) begin
            tick();
            bus.out_ack = (i == od);
            bus.ld_ack  = spur && (i == 1);
        end
        tick();
        bus.out_ack = 1'b0;
        bus.ld_ack  = 1'b0;
        chk("out_req_drop", bus.out_req, 0);
        tick();
    endtask

    task automatic run_job(input int k, input bit stale, input bit fixed);
        int b_ld, b_full, b_cal, b_out, b_done;
        b_ld = c_ldreq; b_full = c_full; b_cal = c_cal; b_out = c_outreq; b_done = c_done;
        bus.k_param = 3'(k);
        bus.start   = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("start_busy", bus.busy, 1);
        chk("start_err_clear", bus.err, 0);
        for (int r = 0; r < k; r++) begin
            if (fixed)
                do_row(r, 3, 0, 2, stale, 4, 1'b0);
            else
                do_row(r, $urandom_range(1, 6), stale ? $urandom_range(1, 3) : $urandom_range(0, 3),
                       $urandom_range(1, 8), stale, $urandom_range(1, 6), 1'($urandom_range(0, 1)));
        end
        chk("done_pulse", bus.done, 1);
        chk("ld_row_fin", bus.ld_row, k - 1);
        tick();
        chk("end_idle_outs", outs(), 11'd0);
        chk("n_ld_req", c_ldreq - b_ld, k);
        chk("n_full", c_full - b_full, k);
        chk("n_cal", c_cal - b_cal, k);
        chk("n_out_req", c_outreq - b_out, k);
        chk("n_done", c_done - b_done, 1);
    endtask

    initial begin
        int b_done, b_out, lat;
        #400000;
        $display("FAIL global_time_limit: got timeout expected finish");
        $fatal(1, "time limit");
    end

    initial begin
        int b_done, b_out, lat;
        reset_n = 1'b0;
        bus.set = 1'b1; bus.start = 1'b0; bus.k_param = 3'd0; bus.abort = 1'b0;
        bus.ld_ack = 1'b0; bus.acc_done = 1'b0; bus.out_ack = 1'b0;
        repeat (3) tick();
        chk("reset_outs", outs(), 11'd0);
        reset_n = 1'b1;
        tick();
        chk("idle_outs", outs(), 11'd0);

        // Legal/illegal k table; legal starts are aborted straight away.
        tbl[0] = '{3'd5, 2'd1, 1'b0}; tbl[1] = '{3'd2, 2'd0, 1'b1};
        tbl[2] = '{3'd0, 2'd1, 1'b0}; tbl[3] = '{3'd3, 2'd0, 1'b1};
        tbl[4] = '{3'd7, 2'd1, 1'b0}; tbl[5] = '{3'd4, 2'd0, 1'b1};
        tbl[6] = '{3'd1, 2'd1, 1'b0}; tbl[7] = '{3'd6, 2'd1, 1'b0};
        for (int i = 0; i < 8; i++) begin
            bus.k_param = tbl[i].k;
            bus.start   = 1'b1;
            tick();
            bus.start = 1'b0;
            chk("tbl_err", bus.err, tbl[i].err_exp);
            chk("tbl_busy", bus.busy, tbl[i].busy_exp);
            chk("tbl_ld_req", bus.ld_req, tbl[i].busy_exp);
            if (tbl[i].busy_exp) begin
                bus.abort = 1'b1;
                tick();
                bus.abort = 1'b0;
                chk("tbl_abort_outs", outs(), 11'd0);
            end
        end
        run_job(3, 1'b0, 1'b0);

        run_job(2, 1'b0, 1'b1);
        bus.acc_done = 1'b1;
        run_job(4, 1'b1, 1'b0);

        // Loader never answers; a start during LD_WAIT must be ignored.
        b_done = c_done;
        bus.k_param = 3'd2; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 1) begin bus.k_param = 3'd7; bus.start = 1'b1; end
            else bus.start = 1'b0;
        end
        chk("to_pre_err", bus.err, 0);
        chk("to_pre_busy", bus.busy, 1);
        tick();
        chk("to_err", bus.err, 2);
        chk("to_busy", bus.busy, 0);
        chk("to_no_done", c_done - b_done, 0);

        // Five held cycles in LD_WAIT push the timeout back by five.
        bus.k_param = 3'd3; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("frz_err_clear", bus.err, 0);
        for (int i = 1; i <= 25; i++) begin
            tick();
            if (i == 3) bus.set = 1'b0;
            if (i >= 4 && i <= 8) chk("frz_busy", {bus.busy, bus.ld_row, bus.ld_req}, 5'b1_000_0);
            if (i == 8) bus.set = 1'b1;
        end
        chk("frz_pre_err", bus.err, 0);
        tick();
        chk("frz_err", bus.err, 2);
        chk("frz_busy_end", bus.busy, 0);

        // Abort while waiting for completion on row 1.
        b_done = c_done; b_out = c_outreq;
        bus.k_param = 3'd2; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        do_row(0, 2, 0, 2, 1'b0, 2, 1'b0);
        chk("ab_row1", bus.ld_row, 1);
        tick(); bus.ld_ack = 1'b1;
        tick(); bus.ld_ack = 1'b0;
        chk("ab_full", bus.acc_full_in, 1);
        tick();
        chk("ab_cal", bus.acc_cal_en, 1);
        bus.acc_done = 1'b0;
        tick(); tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("ab_outs", outs(), 11'd0);
        bus.acc_done = 1'b1;
        repeat (3) tick();
        chk("ab_idle", bus.busy, 0);
        chk("ab_out_cnt", c_outreq - b_out, 1);
        chk("ab_no_done", c_done - b_done, 0);

        // Asynchronous reset during OUT_WAIT; the late out_ack must not revive it.
        b_done = c_done;
        bus.k_param = 3'd2; bus.start = 1'b1;
        tick();
        bus.start = 1'b0; bus.acc_done = 1'b0;
        tick(); bus.ld_ack = 1'b1;
        tick(); bus.ld_ack = 1'b0;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 4) bus.acc_done = 1'b1;
            if (bus.out_req) begin lat = i; break; end
        end
        chk("rst_seq_out_req", bus.out_req, 1);
        tick();
        #2 reset_n = 1'b0;
        #1 chk("rst_async_outs", outs(), 11'd0);
        tick();
        chk("rst_low_outs", outs(), 11'd0);
        reset_n = 1'b1;
        bus.out_ack = 1'b1;
        tick();
        bus.out_ack = 1'b0;
        repeat (3) tick();
        chk("rst_after_outs", outs(), 11'd0);
        chk("rst_no_done", c_done - b_done, 0);
        run_job(2, 1'b1, 1'b0);

        for (int j = 0; j < 6; j++) begin
            bus.acc_done = 1'($urandom_range(0, 1));
            run_job($urandom_range(2, 4), bus.acc_done, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
